hazard_pipeline_regs: RTL
=========================

Name:
hazard_pipeline_regs

Overview:
Pipeline-register bank for the 5-stage ARM core. It is the consumer end of the hazard interface: it obeys stall_f, stall_d, flush_d and flush_e, and it produces the stage-tagged register addresses and control bits (E/M/W) that the hazard unit compares. It holds the PC, F/D, D/E, E/M and M/W registers. Conditional-execution gating is applied at the E→M boundary.

Parameters:
DATA_W, 32, datapath width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall_f  in  1  hold the PC register
stall_d  in  1  hold the F/D register
flush_d  in  1  bubble the F/D register
flush_e  in  1  bubble the D/E register
cond_ex  in  1  condition passed for the instruction in E
pc_next  in  DATA_W  next PC
pc_f  out  DATA_W  current fetch PC
instr_f  in  32  fetched instruction
instr_d  out  32  instruction in Decode
ctrl_d  in  6  decode control {reg_write, mem_to_reg, mem_write, branch, pc_src, alu_src}, bit 5 down to 0
ra1_d  in  4  source register 1 in D
ra2_d  in  4  source register 2 in D
wa3_d  in  4  destination register in D
data_d  in  3*DATA_W  {rd1, rd2, ext_imm}
ctrl_e  out  6  E control; mem_to_reg_e=ctrl_e[4], branch_e=ctrl_e[2]
ra1_e  out  4  source register 1 in E
ra2_e  out  4  source register 2 in E
wa3_e  out  4  destination register in E
data_e  out  3*DATA_W  E operands
result_e  in  2*DATA_W  {alu_result, write_data}
ctrl_m  out  6  gated M control
wa3_m  out  4  destination register in M
data_m  out  2*DATA_W  M payload
result_m  in  2*DATA_W  {alu_out, read_data}
ctrl_w  out  6  W control
wa3_w  out  4  destination register in W
data_w  out  2*DATA_W  W payload

Behaviour:
- All registers update on the rising edge of clk.
- reset has priority over stall and flush. On reset: pc_f=RESET_PC; every other output is 0, including instr_d=0x00000000.
- PC register: pc_f<=pc_next when stall_f=0; otherwise it holds.
- F/D priority, highest first: flush_d → instr_d<=0; else stall_d → hold; else instr_d<=instr_f. flush_d wins over a simultaneous stall_d.
- D/E: flush_e → ctrl_e, ra1_e, ra2_e, wa3_e and data_e all <=0. Otherwise load from the D inputs every cycle; there is no E stall.
- E/M: always loads. ctrl_m<=ctrl_e, with bits 5 (reg_write), 3 (mem_write) and 1 (pc_src) ANDed with cond_ex; bits 4, 2 and 0 pass through unchanged. wa3_m<=wa3_e; data_m<=result_e.
- M/W: always loads. ctrl_w<=ctrl_m, wa3_w<=wa3_m, data_w<=result_m.
- Latency: one cycle per stage. A field presented at D appears at E, M and W after 1, 2 and 3 edges.
- Bubbles have all control bits 0. A bubble therefore never asserts reg_write, mem_to_reg or pc_src toward the hazard unit, even though its wa3 is 0.
- Stall and flush are independent per stage. A D/E flush does not disturb M or W; in-flight instructions drain normally.
- Reset mid-stream discards all in-flight state in one edge. There is no partial retirement.

Test Plan:
1. reset=1 with stall_f=1 and pc_next=0x40 → after the edge, pc_f=RESET_PC (0x0) and all ctrl_*, wa3_* and instr_d are 0.
2. Load-use stall: stall_f=stall_d=flush_e=1 for 1 cycle, instr_f=0xE5912000 → pc_f and instr_d hold; ctrl_e=0 next cycle; the previous E contents advance to M unchanged.
3. stall_d=1 and flush_d=1 together with instr_d=0xE0821003 → instr_d=0x00000000 after the edge.
4. ctrl_e=6'b101011 → ctrl_m=6'b000001 when cond_ex=0; ctrl_m=6'b101011 when cond_ex=1.
5. Stream with no hazards, wa3_d=3 and ctrl_d=6'b100000 at cycle n → wa3_e=3 at n+1, wa3_m=3 with ctrl_m[5]=1 at n+2, wa3_w=3 with ctrl_w[5]=1 at n+3.

Source files
------------

// File: rtl/hazard_pipeline_regs.sv
// hazard_pipeline_regs: PC, F/D, D/E, E/M and M/W pipeline registers with stall, flush and condition gating
module hazard_pipeline_regs #(
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_f,
    input  logic                  stall_d,
    input  logic                  flush_d,
    input  logic                  flush_e,
    input  logic                  cond_ex,
    input  logic [DATA_W-1:0]     pc_next,
    output logic [DATA_W-1:0]     pc_f,
    input  logic [31:0]           instr_f,
    output logic [31:0]           instr_d,
    input  logic [5:0]            ctrl_d,
    input  logic [3:0]            ra1_d,
    input  logic [3:0]            ra2_d,
    input  logic [3:0]            wa3_d,
    input  logic [3*DATA_W-1:0]   data_d,
    output logic [5:0]            ctrl_e,
    output logic [3:0]            ra1_e,
    output logic [3:0]            ra2_e,
    output logic [3:0]            wa3_e,
    output logic [3*DATA_W-1:0]   data_e,
    input  logic [2*DATA_W-1:0]   result_e,
    output logic [5:0]            ctrl_m,
    output logic [3:0]            wa3_m,
    output logic [2*DATA_W-1:0]   data_m,
    input  logic [2*DATA_W-1:0]   result_m,
    output logic [5:0]            ctrl_w,
    output logic [3:0]            wa3_w,
    output logic [2*DATA_W-1:0]   data_w
);
    logic [5:0] condMask;
    always_comb condMask = {cond_ex, 1'b1, cond_ex, 1'b1, cond_ex, 1'b1};
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f    <= RESET_PC;
            instr_d <= '0;
            ctrl_e  <= '0;
            ra1_e   <= '0;
            ra2_e   <= '0;
            wa3_e   <= '0;
            data_e  <= '0;
            ctrl_m  <= '0;
            wa3_m   <= '0;
            data_m  <= '0;
            ctrl_w  <= '0;
            wa3_w   <= '0;
            data_w  <= '0;
        end else begin
            pc_f    <= stall_f ? pc_f : pc_next;
            instr_d <= flush_d ? '0 : stall_d ? instr_d : instr_f;
            ctrl_e  <= flush_e ? '0 : ctrl_d;
            ra1_e   <= flush_e ? '0 : ra1_d;
            ra2_e   <= flush_e ? '0 : ra2_d;
            wa3_e   <= flush_e ? '0 : wa3_d;
            data_e  <= flush_e ? '0 : data_d;
            ctrl_m  <= ctrl_e & condMask;
            wa3_m   <= wa3_e;
            data_m  <= result_e;
            ctrl_w  <= ctrl_m;
            wa3_w   <= wa3_m;
            data_w  <= result_m;
        end
    end
endmodule
